dsp_frame_loader: RTL and testbench
===================================

// Module: dsp_frame_loader
// PURPOSE
//  Upstream stage of the DSP egress transmitter. Accepts one frame of 32-bit words over a
//  valid/ready stream with SOP/EOP marks and writes it into a 2**AW x 32 frame buffer.
//  Once a complete, legal frame is stored, raises start_send and holds the buffer
//  read-only until the transmitter reports completion (tx_done).
//  Read port (rdaddr -> datain) is driven by the egress transmitter.
// PARAMETERS
//  AW          10       buffer address width; DEPTH = 2**AW words
//  MIN_WORDS   12       minimum legal frame length in words (length field sits at word 10)
//  START_HOLD  4        cycles start_send is held high (must be >= 3; receiver double-syncs)
//  TO_CYCLES   1000000  WAIT_TX timeout in TFCLK cycles (24-bit counter)
// PORTS
//  TFCLK       in   1    clock
//  nRST        in   1    reset, asynchronous, active-low
//  in_valid    in   1    input word valid
//  in_data     in   32   input word
//  in_sop      in   1    first word of frame (qualified by in_valid)
//  in_eop      in   1    last word of frame (qualified by in_valid)
//  in_ready    out  1    loader accepts a word this cycle
//  rdaddr      in   AW   transmitter read address
//  datain      out  32   buffer read data, registered, 1-cycle latency
//  start_send  out  1    frame ready; level held START_HOLD cycles
//  tx_done     in   1    transmitter end-of-frame pulse (connect to TEOP)
//  frame_len   out  AW+1 word count of the stored frame
//  buf_busy    out  1    buffer holds a frame not yet released
//  frm_cnt     out  16   frames handed to the transmitter, wraps at 0xFFFF
//  drop_cnt    out  16   frames/words discarded, saturates at 0xFFFF
//  ovf_err     out  1    1-cycle pulse: frame exceeded DEPTH
//  to_err      out  1    1-cycle pulse: WAIT_TX timeout
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, start_send=0, buf_busy=0, frame_len=0, frm_cnt=0,
//   drop_cnt=0, ovf_err=0, to_err=0, datain=0, wr_ptr=0. RAM contents are not cleared.
//  Accepted beat = in_valid & in_ready. Write into RAM takes effect on the same edge.
//  Read: datain <= mem[rdaddr] every cycle, in every state.
//  IDLE (in_ready=1): beat with sop writes mem[0], wr_ptr=1, goes to LOAD.
//   Beat without sop is discarded, drop_cnt+1. Beat with sop&eop is a 1-word frame:
//   too short, so it is discarded, drop_cnt+1, stays in IDLE.
//  LOAD (in_ready=1): beat writes mem[wr_ptr], wr_ptr+1.
//   Beat with sop (restart): writes mem[0], wr_ptr=1, drop_cnt+1.
//   Beat with eop: len = wr_ptr+1.
//    If len < MIN_WORDS: drop_cnt+1, goes to IDLE.
//    Otherwise: frame_len <= len, goes to ARM.
//   Non-eop beat at wr_ptr = DEPTH-1: ovf_err pulse, drop_cnt+1, goes to DISCARD.
//  DISCARD (in_ready=1): sinks beats without writing until the eop beat, then goes to IDLE.
//   A sop beat here starts a new frame exactly as in IDLE.
//  ARM (in_ready=0, buf_busy=1): start_send=1 for exactly START_HOLD cycles,
//   frm_cnt+1 on entry, then goes to WAIT_TX.
//  WAIT_TX (in_ready=0, buf_busy=1, start_send=0):
//   tx_done goes to IDLE and clears buf_busy.
//   TO_CYCLES elapsed without tx_done: to_err pulse, goes to IDLE.
//   A tx_done in ARM is ignored.
//  Release: in_ready rises the cycle after leaving WAIT_TX. No beat is accepted in ARM/WAIT_TX.
//  Reset mid-frame or mid-send: immediate return to IDLE. Partial frame is abandoned.
//   start_send drops asynchronously.
//  drop_cnt saturates; frm_cnt wraps.
// TESTING
//  1. 56-word frame (word k = 0xA5000000+k), sop@0, eop@55 -> frame_len=56, start_send high
//     4 cycles, rdaddr=10 gives datain=0xA500000A next cycle, frm_cnt=1.
//  2. Back-to-back frame while WAIT_TX -> in_ready=0, RAM unchanged. Pulse tx_done ->
//     in_ready=1 next cycle, second frame loads.
//  3. 5-word frame -> no start_send, drop_cnt=1. Single-beat sop&eop -> drop_cnt=2.
//  4. 1030 words without eop -> ovf_err pulse at word 1024, words to eop sunk, state IDLE.
//  5. sop at word 20 of frame in LOAD -> restart at addr 0, drop_cnt+1, new frame_len correct.
//  6. No tx_done for TO_CYCLES -> to_err pulse, buf_busy=0. nRST low mid-LOAD -> all outputs
//     at reset values.

Source files
------------

// File: rtl/dsp_frame_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dsp_frame_loader
//
// Upstream stage of the DSP egress transmitter. Collects one frame of 32-bit
// words from a SOP/EOP-marked stream into a 2**AW x 32 frame buffer. Once a
// complete frame of legal length is stored, it raises start_send and keeps the
// buffer read-only until the transmitter reports tx_done, or until a timeout
// expires.
//
// Handshake: a word transfers on a rising TFCLK edge where in_valid and
// in_ready are both high. in_valid may rise regardless of in_ready, and
// in_ready is decoded from the state register only, so it never depends on
// in_valid in the same cycle.
//
// Ports
//   TFCLK, nRST       clock; asynchronous active-low reset
//   in_valid/in_data  input word stream, in_sop/in_eop mark first/last word
//   in_ready          loader accepts a word this cycle
//   rdaddr/datain     transmitter read port, registered, 1-cycle latency
//   start_send        frame ready, held high START_HOLD cycles
//   tx_done           transmitter end-of-frame pulse
//   frame_len         word count of the stored frame
//   buf_busy          buffer holds a frame not yet released
//   frm_cnt           frames handed to the transmitter (wraps)
//   drop_cnt          discarded frames/words (saturates)
//   ovf_err, to_err   1-cycle pulses: overflow / WAIT_TX timeout
//   dbg_state_o       current FSM state, for observation only
// -----------------------------------------------------------------------------
module dsp_frame_loader #(
  parameter int AW         = 10,
  parameter int MIN_WORDS  = 12,
  parameter int START_HOLD = 4,
  parameter int TO_CYCLES  = 1000000
) (
  input  logic          TFCLK,
  input  logic          nRST,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  input  logic          in_sop,
  input  logic          in_eop,
  output logic          in_ready,
  input  logic [AW-1:0] rdaddr,
  output logic [31:0]   datain,
  output logic          start_send,
  input  logic          tx_done,
  output logic [AW:0]   frame_len,
  output logic          buf_busy,
  output logic [15:0]   frm_cnt,
  output logic [15:0]   drop_cnt,
  output logic          ovf_err,
  output logic          to_err,
  output logic [2:0]    dbg_state_o
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0]   MIN_LEN   = (AW+1)'(MIN_WORDS);
  localparam logic [23:0]   HOLD_LAST = 24'(START_HOLD - 1);
  localparam logic [23:0]   TO_LAST   = 24'(TO_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_DISCARD = 3'd2,
    S_ARM     = 3'd3,
    S_WAIT_TX = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   frame_len_q, frame_len_d;
  logic [23:0]   cnt_q, cnt_d;
  logic [15:0]   frm_cnt_q, drop_cnt_q;
  logic          ovf_q, ovf_d;
  logic          to_q, to_d;
  logic [31:0]   datain_q;
  logic          frm_inc, drop_inc;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW:0]   len_w;
  logic          beat;

  logic [31:0]   mem [DEPTH];

  // Moore outputs: decoded from the state register alone, so an asynchronous
  // reset drops start_send immediately.
  assign in_ready    = (state_q == S_IDLE) || (state_q == S_LOAD) ||
                       (state_q == S_DISCARD);
  assign start_send  = (state_q == S_ARM);
  assign buf_busy    = (state_q == S_ARM) || (state_q == S_WAIT_TX);
  assign beat        = in_valid & in_ready;
  assign frame_len   = frame_len_q;
  assign frm_cnt     = frm_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign ovf_err     = ovf_q;
  assign to_err      = to_q;
  assign datain      = datain_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    frame_len_d = frame_len_q;
    cnt_d       = cnt_q;
    frm_inc     = 1'b0;
    drop_inc    = 1'b0;
    ovf_d       = 1'b0;
    to_d        = 1'b0;
    we          = 1'b0;
    waddr       = wr_ptr_q;
    len_w       = {1'b0, wr_ptr_q} + (AW+1)'(1);
    case (state_q)
      // DISCARD reacts to a SOP exactly like IDLE; only non-SOP beats differ.
      S_IDLE, S_DISCARD: begin
        if (beat) begin
          if (in_sop && !in_eop) begin
            we       = 1'b1;
            waddr    = '0;
            wr_ptr_d = AW'(1);
            state_d  = S_LOAD;
          end else if (in_sop) begin
            // Single-word frame can never reach the minimum length.
            drop_inc = 1'b1;
            state_d  = S_IDLE;
          end else if (state_q == S_IDLE) begin
            drop_inc = 1'b1;
          end else if (in_eop) begin
            state_d  = S_IDLE;
          end
        end
      end
      S_LOAD: begin
        if (beat) begin
          we = 1'b1;
          if (in_sop) begin
            // Restart: abandon the partial frame. A SOP+EOP restart is a
            // one-word frame and is abandoned as well, counted once.
            waddr    = '0;
            wr_ptr_d = AW'(1);
            drop_inc = 1'b1;
            if (in_eop) state_d = S_IDLE;
          end else if (in_eop) begin
            if (len_w < MIN_LEN) begin
              drop_inc = 1'b1;
              state_d  = S_IDLE;
            end else begin
              frame_len_d = len_w;
              frm_inc     = 1'b1;
              cnt_d       = '0;
              state_d     = S_ARM;
            end
          end else if (wr_ptr_q == {AW{1'b1}}) begin
            ovf_d    = 1'b1;
            drop_inc = 1'b1;
            state_d  = S_DISCARD;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      S_ARM: begin
        // tx_done is deliberately ignored while start_send is held.
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_TX;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_WAIT_TX: begin
        if (tx_done) begin
          state_d = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          to_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge TFCLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      frame_len_q <= '0;
      cnt_q       <= '0;
      frm_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      to_q        <= 1'b0;
      datain_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      frame_len_q <= frame_len_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      to_q        <= to_d;
      datain_q    <= mem[rdaddr];
      if (frm_inc) frm_cnt_q <= frm_cnt_q + 16'd1;
      if (drop_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  // Buffer contents survive reset.
  always_ff @(posedge TFCLK) begin
    if (we) mem[waddr] <= in_data;
  end

endmodule

// File: tb/tb_dsp_frame_loader.sv
`timescale 1ns/1ps
module tb_dsp_frame_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int MINW  = 12;
  localparam int HOLD  = 4;
  localparam int TO    = 300;

  // ---------------- clock / reset ----------------
  logic          TFCLK = 1'b0;
  logic          nRST  = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data  = '0;
  logic          in_sop   = 1'b0;
  logic          in_eop   = 1'b0;
  logic          in_ready;
  logic [AW-1:0] rdaddr   = '0;
  logic [31:0]   datain;
  logic          start_send;
  logic          tx_done  = 1'b0;
  logic [AW:0]   frame_len;
  logic          buf_busy;
  logic [15:0]   frm_cnt;
  logic [15:0]   drop_cnt;
  logic          ovf_err;
  logic          to_err;
  logic [2:0]    dbg_state;

  always #5 TFCLK = ~TFCLK;

  dsp_frame_loader #(
    .AW(AW), .MIN_WORDS(MINW), .START_HOLD(HOLD), .TO_CYCLES(TO)
  ) dut (
    .TFCLK(TFCLK), .nRST(nRST),
    .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready), .rdaddr(rdaddr), .datain(datain),
    .start_send(start_send), .tx_done(tx_done), .frame_len(frame_len),
    .buf_busy(buf_busy), .frm_cnt(frm_cnt), .drop_cnt(drop_cnt),
    .ovf_err(ovf_err), .to_err(to_err), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] cur_q[$];    // words of the frame being collected
  logic [31:0] exp_q[$];    // last frame that should sit in the buffer
  int          mdl_mode;    // 0: idle, 1: collecting, 2: sinking to eop
  int          exp_drop, exp_frm, exp_len;
  bit          armed, exp_ovf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    cur_q.delete();
    mdl_mode = 0;
    exp_drop = 0;
    exp_frm  = 0;
    exp_len  = 0;
    armed    = 0;
    exp_ovf  = 0;
  endfunction

  function automatic void mdl_drop();
    if (exp_drop < 65535) exp_drop++;
  endfunction

  // One accepted word, applied to the frame rules.
  function automatic void mdl_beat(input logic [31:0] d, input bit sop, input bit eop);
    exp_ovf = 0;
    if (mdl_mode == 1) begin
      if (sop) begin
        mdl_drop();
        cur_q.delete();
        cur_q.push_back(d);
        if (eop) mdl_mode = 0;
      end else if (eop) begin
        cur_q.push_back(d);
        mdl_mode = 0;
        if (cur_q.size() < MINW) mdl_drop();
        else begin
          exp_q   = cur_q;
          exp_len = cur_q.size();
          exp_frm = (exp_frm + 1) & 16'hFFFF;
          armed   = 1;
        end
      end else if (cur_q.size() == DEPTH - 1) begin
        exp_ovf  = 1;
        mdl_drop();
        mdl_mode = 2;
      end else begin
        cur_q.push_back(d);
      end
    end else begin
      if (sop && !eop) begin
        cur_q.delete();
        cur_q.push_back(d);
        mdl_mode = 1;
      end else if (sop) begin
        mdl_drop();
        mdl_mode = 0;
      end else if (mdl_mode == 0) begin
        mdl_drop();
      end else if (eop) begin
        mdl_mode = 0;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic reset_checks(input string tag);
    check_eq({tag, "_in_ready"},   in_ready,   1);
    check_eq({tag, "_start_send"}, start_send, 0);
    check_eq({tag, "_buf_busy"},   buf_busy,   0);
    check_eq({tag, "_frame_len"},  frame_len,  0);
    check_eq({tag, "_frm_cnt"},    frm_cnt,    0);
    check_eq({tag, "_drop_cnt"},   drop_cnt,   0);
    check_eq({tag, "_ovf_err"},    ovf_err,    0);
    check_eq({tag, "_to_err"},     to_err,     0);
    check_eq({tag, "_datain"},     datain,     0);
  endtask

  // Entered and left at posedge+1.
  task automatic send(input logic [31:0] d, input bit sop, input bit eop, input int gap);
    in_valid = 1'b0;
    repeat (gap) begin @(posedge TFCLK); #1; end
    check_eq("in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop;
    @(posedge TFCLK);
    mdl_beat(d, sop, eop);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    check_eq("ovf_err", ovf_err, exp_ovf);
    check_eq("drop_cnt", drop_cnt, exp_drop);
  endtask

  task automatic send_frame(input int len, input int restart_at, input logic [31:0] base,
                            input int max_gap);
    for (int k = 0; k < len; k++) begin
      logic [31:0] d;
      d = (base != 0) ? base + k : $urandom;
      send(d, (k == 0) || (restart_at > 0 && k == restart_at), k == len - 1,
           $urandom_range(0, max_gap));
    end
  endtask

  task automatic arm_check(input bit poke_done);
    check_eq("frame_len", frame_len, exp_len);
    check_eq("frm_cnt",   frm_cnt,   exp_frm);
    for (int i = 0; i <= HOLD; i++) begin
      check_eq("start_send_hold", start_send, (i < HOLD) ? 1 : 0);
      check_eq("busy_armed",      buf_busy,   1);
      check_eq("ready_armed",     in_ready,   0);
      if (i < HOLD) begin
        tx_done = poke_done && (i == 1);
        @(posedge TFCLK); #1;
        tx_done = 1'b0;
      end
    end
  endtask

  task automatic release_done();
    tx_done = 1'b1;
    @(posedge TFCLK); #1;
    tx_done = 1'b0;
    check_eq("ready_after_done", in_ready, 1);
    check_eq("busy_after_done",  buf_busy, 0);
    check_eq("to_err_quiet",     to_err,   0);
  endtask

  task automatic release_timeout();
    int n;
    n = 0;
    while (to_err !== 1'b1 && n < TO + 20) begin
      @(posedge TFCLK); #1;
      n++;
    end
    check_eq("timeout_cycles", n, TO);
    check_eq("to_err_pulse",   to_err, 1);
    check_eq("busy_after_to",  buf_busy, 0);
    check_eq("ready_after_to", in_ready, 1);
    @(posedge TFCLK); #1;
    check_eq("to_err_one_cycle", to_err, 0);
  endtask

  task automatic readback();
    for (int k = 0; k < exp_q.size(); k++) begin
      rdaddr = AW'(k);
      @(posedge TFCLK); #1;
      check_eq($sformatf("rd[%0d]", k), datain, exp_q[k]);
    end
  endtask

  // how: 0 tx_done, 1 timeout, 2 tx_done poked during ARM, 3 held input during WAIT_TX
  task automatic finish_frame(input int how);
    if (armed) begin
      armed = 0;
      arm_check(how == 2);
      if (how == 3) begin
        in_valid = 1'b1; in_sop = 1'b1; in_data = 32'hDEAD_BEEF;
        repeat (3) begin
          check_eq("ready_blocked", in_ready, 0);
          @(posedge TFCLK); #1;
        end
        in_valid = 1'b0; in_sop = 1'b0;
      end
      if (how == 1) release_timeout();
      else          release_done();
      readback();
    end else begin
      check_eq("no_start_send", start_send, 0);
      check_eq("not_busy",      buf_busy,   0);
    end
  endtask

  task automatic async_reset(input string tag);
    #2 nRST = 1'b0;
    #1 reset_checks(tag);
    mdl_reset();
    @(negedge TFCLK);
    nRST = 1'b1;
    @(posedge TFCLK); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    mdl_reset();
    repeat (3) @(posedge TFCLK);
    #1 reset_checks("rst_hold");
    @(negedge TFCLK);
    nRST = 1'b1;
    @(posedge TFCLK); #1;
    reset_checks("rst_init");

    // 56-word frame with known data; blocked input while waiting; second frame.
    send_frame(56, 0, 32'hA500_0000, 0);
    check_eq("armed_56", armed, 1);
    finish_frame(3);
    check_eq("word10", exp_q[10], 32'hA500_000A);
    send_frame(20, 0, 32'h0, 2);
    finish_frame(2);

    // Short frame, then single sop&eop word.
    send_frame(5, 0, 32'h0, 1);
    finish_frame(0);
    send_frame(1, 0, 32'h0, 0);
    finish_frame(0);

    // Overflow: 1030 words without eop, then the eop word.
    send_frame(1031, 0, 32'h0, 0);
    finish_frame(0);
    send_frame(14, 0, 32'h0, 0);
    finish_frame(0);

    // Restart at word 20.
    send_frame(50, 20, 32'h0, 1);
    finish_frame(0);

    // Timeout.
    send_frame(12, 0, 32'h0, 0);
    finish_frame(1);

    // Reset mid-LOAD and mid-ARM.
    send_frame(7, 0, 32'h0, 0);
    send(32'h1234_5678, 1'b0, 1'b0, 0);
    async_reset("rst_load");
    send_frame(16, 0, 32'h0, 0);
    async_reset("rst_arm");

    // Random mix.
    for (int it = 0; it < 24; it++) begin
      int r;
      int len;
      r = $urandom_range(0, 9);
      case (r)
        0: begin
          repeat ($urandom_range(1, 3))
            send($urandom, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
          finish_frame(0);
        end
        1: begin
          send_frame($urandom_range(2, MINW - 1), 0, 32'h0, 2);
          finish_frame(0);
        end
        2: begin
          send_frame(1, 0, 32'h0, 1);
          finish_frame(0);
        end
        default: begin
          len = $urandom_range(MINW, 64);
          send_frame(len, (r == 3) ? $urandom_range(1, len - 1) : 0, 32'h0, 2);
          finish_frame((r == 4) ? 1 : (r == 5) ? 3 : $urandom_range(0, 1) * 2);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
